// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the coherence bus controller.
//   word_t      : one 32-bit data/address word
//   ramstate_t  : handshake state reported by the RAM port
//   bus_state_t : bus controller FSM states
//   BLOCK_WORDS : words per cache block moved by a fetch or a snoop writeback
package cpu_types_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        DECIDE,
        SNOOPWB,
        READ,
        WRITE,
        DONE
    } bus_state_t;

    // A RAM word finishes on ACCESS or ERROR; ERROR still hands data back.
    function automatic logic is_word_done(input ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_arb.sv
// Two-requester round-robin arbiter.
//   CLK, RST : clock, synchronous active-high reset (pointer -> core 0)
//   req      : request vector
//   update   : strobe; the core named by 'served' loses priority
//   served   : index of the core whose transaction just finished
//   grant    : granted index (valid only when valid=1)
//   valid    : at least one request present
module rr_arbiter_2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       grant,
    output logic       valid
);

    logic ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~served;
        end
    end

    always_comb begin
        valid = |req;
        grant = (req == 2'b11) ? ptr : req[1];
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller between two dcaches and a single RAM port.
// Serves one transaction at a time: a two-word block fetch (with a snoop of
// the other core and an optional dirty writeback first) or a write burst.
//   CLK, RST               : clock, synchronous active-high reset
//   dREN/dWEN/daddr/dstore : per-core word requests
//   ccwrite                : requester wants ownership (snooper invalidates)
//   cctrans                : informational, not used for control
//   dwait/dload            : per-core completion (low one cycle) and read data
//   ccwait/ccinv/ccsnoopaddr : snoop presented to the non-requesting core
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate : RAM port
//   bus_err                : sticky, set when a word completes with ERROR
//
// state   | meaning
// IDLE    | arbitrate between requesting cores
// SNOOP   | present snoop address/invalidate to the other core
// DECIDE  | other core answers: dirty (dWEN) or clean
// SNOOPWB | write the snooper's dirty block back to RAM
// READ    | fetch the requester's block from RAM
// WRITE   | plain write burst from the requester, no snoop
// DONE    | drop snoop, rotate priority, gap cycle before re-arbitration
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int WORD_W = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NCORES-1:0]              dREN,
    input  logic [NCORES-1:0]              dWEN,
    input  logic [NCORES-1:0][WORD_W-1:0]  daddr,
    input  logic [NCORES-1:0][WORD_W-1:0]  dstore,
    input  logic [NCORES-1:0]              ccwrite,
    input  logic [NCORES-1:0]              cctrans,
    output logic [NCORES-1:0]              dwait,
    output logic [NCORES-1:0][WORD_W-1:0]  dload,
    output logic [NCORES-1:0]              ccwait,
    output logic [NCORES-1:0]              ccinv,
    output logic [NCORES-1:0][WORD_W-1:0]  ccsnoopaddr,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [WORD_W-1:0]              ramaddr,
    output logic [WORD_W-1:0]              ramstore,
    input  logic [WORD_W-1:0]              ramload,
    input  ramstate_t                      ramstate,
    output logic                           bus_err
);

    localparam logic [1:0] LAST_WORD = 2'(BLOCK_WORDS - 1);

    bus_state_t          state, state_n;
    logic                gnt_q, gnt_n;
    logic                other;
    logic [1:0]          word_cnt, word_cnt_n;
    logic [WORD_W-1:0]   snp_addr_q, snp_addr_n;
    logic                snp_inv_q, snp_inv_n;
    logic                word_done;
    logic                wdone;
    logic [NCORES-1:0]   arb_req;
    logic                arb_grant, arb_valid;
    logic                unused_cctrans;

    assign unused_cctrans = ^cctrans;
    assign other          = ~gnt_q;
    assign word_done      = is_word_done(ramstate);
    assign arb_req        = (dREN | dWEN) & ~ccwait;

    rr_arbiter_2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    (arb_req),
        .update (state == DONE),
        .served (gnt_q),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    always_comb begin
        for (int k = 0; k < NCORES; k++) begin
            dload[k] = ramload;
        end
    end

    // Snoop outputs depend on state only; address and invalidate were
    // captured at grant so they stay stable for the whole snoop window.
    always_comb begin
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        if (state == SNOOP || state == DECIDE || state == SNOOPWB || state == READ) begin
            ccwait[other]      = 1'b1;
            ccinv[other]       = snp_inv_q;
            ccsnoopaddr[other] = snp_addr_q;
        end
    end

    always_comb begin
        state_n    = state;
        gnt_n      = gnt_q;
        word_cnt_n = word_cnt;
        snp_addr_n = snp_addr_q;
        snp_inv_n  = snp_inv_q;
        dwait      = '1;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        wdone      = 1'b0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    gnt_n      = arb_grant;
                    snp_addr_n = daddr[arb_grant];
                    snp_inv_n  = ccwrite[arb_grant];
                    state_n    = dWEN[arb_grant] ? WRITE : SNOOP;
                end
            end
            SNOOP: state_n = DECIDE;
            DECIDE: state_n = dWEN[other] ? SNOOPWB : READ;
            SNOOPWB: begin
                if (!dWEN[other]) begin
                    word_cnt_n = '0;
                    state_n    = READ;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[other];
                    ramstore = dstore[other];
                    if (word_done) begin
                        dwait[other] = 1'b0;
                        wdone        = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt_n = '0;
                            state_n    = READ;
                        end else begin
                            word_cnt_n = word_cnt + 2'd1;
                        end
                    end
                end
            end
            READ: begin
                // Requester may give up the rest of the block after one word.
                if (word_cnt != '0 && !dREN[gnt_q]) begin
                    word_cnt_n = '0;
                    state_n    = DONE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[gnt_q];
                    if (word_done) begin
                        dwait[gnt_q] = 1'b0;
                        wdone        = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt_n = '0;
                            state_n    = DONE;
                        end else begin
                            word_cnt_n = word_cnt + 2'd1;
                        end
                    end
                end
            end
            WRITE: begin
                if (!dWEN[gnt_q]) begin
                    state_n = DONE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[gnt_q];
                    ramstore = dstore[gnt_q];
                    if (word_done) begin
                        dwait[gnt_q] = 1'b0;
                        wdone        = 1'b1;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            gnt_q      <= 1'b0;
            word_cnt   <= '0;
            snp_addr_q <= '0;
            snp_inv_q  <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_n;
            gnt_q      <= gnt_n;
            word_cnt   <= word_cnt_n;
            snp_addr_q <= snp_addr_n;
            snp_inv_q  <= snp_inv_n;
            if (wdone && ramstate == ERROR) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    logic               CLK = 1'b0;
    logic               RST;
    logic [1:0]         dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0]   daddr, dstore, dload, ccsnoopaddr;
    logic [1:0]         dwait, ccwait, ccinv;
    logic               ramREN, ramWEN, bus_err;
    logic [31:0]        ramaddr, ramstore, ramload;
    ramstate_t          ramstate;

    coherence_bus_ctrl #(.NCORES(2), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans), .dwait(dwait),
        .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory: environment RAM and reference prediction
    logic [31:0] ram_mem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // ---------------- RAM model
    int          ram_fixed_lat = -1;
    bit          err_armed = 0;
    logic [31:0] err_addr  = '0;
    bit          ram_busy  = 0;
    int          ram_left  = 0;

    initial begin
        ramstate = FREE;
        ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (ramREN || ramWEN) begin
                if (!ram_busy) begin
                    ram_busy = 1;
                    ram_left = (ram_fixed_lat >= 0) ? ram_fixed_lat : int'($urandom_range(0, 2));
                end
                if (ram_left > 0) begin
                    ramstate = BUSY;
                    ram_left--;
                end else begin
                    if (err_armed && ramREN && ramaddr == err_addr) begin
                        ramstate  = ERROR;
                        err_armed = 0;
                    end else begin
                        ramstate = ACCESS;
                    end
                    if (ramREN) ramload = ram_rd(ramaddr);
                    else        ram_mem[ramaddr] = ramstore;
                    ram_busy = 0;
                end
            end else begin
                ramstate = FREE;
                ram_busy = 0;
            end
        end
    end

    // ---------------- scoreboard queues
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } ram_op_t;
    typedef struct { bit rd; logic [31:0] data; } resp_t;
    typedef struct { int core; logic [31:0] addr; bit inv; } snoop_t;

    ram_op_t exp_ram[$];
    resp_t   exp_resp0[$];
    resp_t   exp_resp1[$];
    snoop_t  exp_snoop[$];
    snoop_t  cur_snoop;

    task automatic push_resp(input int k, input bit rd, input logic [31:0] d);
        resp_t r;
        r.rd = rd; r.data = d;
        if (k == 0) exp_resp0.push_back(r);
        else        exp_resp1.push_back(r);
    endtask

    // Predict a block fetch by core k, optionally preceded by a dirty writeback from the other core.
    task automatic exp_read(input int k, input logic [31:0] a, input bit ccw,
                            input bit dirty, input logic [31:0] d0, input logic [31:0] d1);
        snoop_t s;
        s.core = 1 - k; s.addr = a; s.inv = ccw;
        exp_snoop.push_back(s);
        if (dirty) begin
            exp_ram.push_back('{1'b1, a, d0});
            exp_ram.push_back('{1'b1, a + 32'd4, d1});
            ref_mem[a] = d0;
            ref_mem[a + 32'd4] = d1;
            push_resp(1 - k, 1'b0, d0);
            push_resp(1 - k, 1'b0, d1);
        end
        for (int w = 0; w < 2; w++) begin
            logic [31:0] wa;
            wa = a + 32'(4 * w);
            exp_ram.push_back('{1'b0, wa, ref_rd(wa)});
            push_resp(k, 1'b1, ref_rd(wa));
        end
    endtask

    logic [31:0] wr_data [8];

    task automatic exp_write(input int k, input logic [31:0] a, input int n);
        for (int w = 0; w < n; w++) begin
            exp_ram.push_back('{1'b1, a + 32'(4 * w), wr_data[w]});
            ref_mem[a + 32'(4 * w)] = wr_data[w];
            push_resp(k, 1'b0, wr_data[w]);
        end
    endtask

    // ---------------- monitor
    bit         mon_en = 0;
    bit         no_snoop_chk = 0;
    logic [1:0] prev_ccwait = '0;

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (ramREN && ramWEN) check_eq("strobes_exclusive", 32'd1, 32'd0);
                if ((ramREN || ramWEN) && (ramstate == ACCESS || ramstate == ERROR)) begin
                    if (exp_ram.size() == 0) begin
                        check_eq("unexpected_ram_word", ramaddr, 32'hFFFF_FFFF);
                    end else begin
                        ram_op_t op;
                        op = exp_ram.pop_front();
                        check_eq("ram_is_write", {31'd0, ramWEN}, {31'd0, op.wr});
                        check_eq("ram_addr", ramaddr, op.addr);
                        if (op.wr) check_eq("ram_store", ramstore, op.data);
                        else       check_eq("ram_load", ramload, op.data);
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (!dwait[k]) begin
                        resp_t r;
                        bit    have;
                        have = 0;
                        if (k == 0 && exp_resp0.size() > 0) begin r = exp_resp0.pop_front(); have = 1; end
                        if (k == 1 && exp_resp1.size() > 0) begin r = exp_resp1.pop_front(); have = 1; end
                        check_eq($sformatf("dwait_pulse_expected_core%0d", k), {31'd0, have}, 32'd1);
                        if (have && r.rd) check_eq($sformatf("dload_core%0d", k), dload[k], r.data);
                    end
                    if (ccwait[k] && !prev_ccwait[k]) begin
                        if (exp_snoop.size() == 0) begin
                            check_eq("unexpected_snoop", 32'(k), 32'hFFFF_FFFF);
                        end else begin
                            cur_snoop = exp_snoop.pop_front();
                            check_eq("snoop_core", 32'(k), 32'(cur_snoop.core));
                        end
                    end
                    if (ccwait[k]) begin
                        check_eq("ccsnoopaddr", ccsnoopaddr[k], cur_snoop.addr);
                        check_eq("ccinv", {31'd0, ccinv[k]}, {31'd0, cur_snoop.inv});
                    end
                end
                if (ccwait == 2'b11) check_eq("ccwait_both", 32'(ccwait), 32'd0);
                if (no_snoop_chk) check_eq("ccwait_during_write", 32'(ccwait), 32'd0);
                prev_ccwait = ccwait;
            end
        end
    end

    // ---------------- core drivers
    task automatic drive_read(input int k, input logic [31:0] a, input bit ccw);
        int words, guard;
        words = 0; guard = 0;
        @(posedge CLK); #1;
        dREN[k] = 1'b1; daddr[k] = a; ccwrite[k] = ccw; cctrans[k] = 1'b1;
        while (words < 2 && guard < 300) begin
            @(negedge CLK);
            guard++;
            if (!dwait[k]) begin
                words++;
                @(posedge CLK); #1;
                if (words < 2) daddr[k] = a + 32'd4;
            end
        end
        dREN[k] = 1'b0; ccwrite[k] = 1'b0; cctrans[k] = 1'b0;
        check_eq($sformatf("read_words_core%0d", k), 32'(words), 32'd2);
    endtask

    task automatic drive_snooper_dirty(input int j, input logic [31:0] a,
                                       input logic [31:0] d0, input logic [31:0] d1);
        int words, guard;
        words = 0; guard = 0;
        while (!ccwait[j] && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check_eq("snooper_saw_ccwait", {31'd0, ccwait[j]}, 32'd1);
        @(posedge CLK); #1;
        dWEN[j] = 1'b1; daddr[j] = a; dstore[j] = d0;
        guard = 0;
        while (words < 2 && guard < 300) begin
            @(negedge CLK);
            guard++;
            if (!dwait[j]) begin
                words++;
                @(posedge CLK); #1;
                if (words < 2) begin daddr[j] = a + 32'd4; dstore[j] = d1; end
            end
        end
        dWEN[j] = 1'b0;
        check_eq("snoop_wb_words", 32'(words), 32'd2);
    endtask

    task automatic drive_write(input int k, input logic [31:0] a, input int n);
        int words, guard;
        words = 0; guard = 0;
        @(posedge CLK); #1;
        dWEN[k] = 1'b1; daddr[k] = a; dstore[k] = wr_data[0];
        while (words < n && guard < 400) begin
            @(negedge CLK);
            guard++;
            if (!dwait[k]) begin
                words++;
                @(posedge CLK); #1;
                if (words < n) begin daddr[k] = a + 32'(4 * words); dstore[k] = wr_data[words]; end
            end
        end
        dWEN[k] = 1'b0;
        check_eq("write_words", 32'(words), 32'(n));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // ---------------- watchdog
    initial begin
        repeat (40000) @(posedge CLK);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin
        int c, g;
        dREN = '0; dWEN = '0; daddr = '0; dstore = '0; ccwrite = '0; cctrans = '0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_dwait", 32'(dwait), 32'd3);
        check_eq("rst_ccwait", 32'(ccwait), 32'd0);
        check_eq("rst_ccinv", 32'(ccinv), 32'd0);
        check_eq("rst_ccsnoopaddr0", ccsnoopaddr[0], 32'd0);
        check_eq("rst_ccsnoopaddr1", ccsnoopaddr[1], 32'd0);
        check_eq("rst_ram_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check_eq("rst_ramaddr", ramaddr, 32'd0);
        check_eq("rst_ramstore", ramstore, 32'd0);
        check_eq("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        mon_en = 1;

        // both cores read together: core0 first, then core1
        exp_read(0, 32'h500, 1'b0, 1'b0, '0, '0);
        exp_read(1, 32'h600, 1'b0, 1'b0, '0, '0);
        fork
            drive_read(0, 32'h500, 1'b0);
            drive_read(1, 32'h600, 1'b0);
        join
        idle_cycles(2);

        // clean read, fixed two BUSY cycles per word
        ram_fixed_lat = 2;
        preload(32'h100, 32'h0000_AAAA);
        preload(32'h104, 32'h0000_BBBB);
        exp_read(0, 32'h100, 1'b0, 1'b0, '0, '0);
        fork
            drive_read(0, 32'h100, 1'b0);
            begin
                c = 0; g = 0;
                while (!ccwait[1] && g < 50) begin @(negedge CLK); g++; end
                while (ccwait[1] && !ramREN && g < 100) begin c++; @(negedge CLK); g++; end
                check_eq("snoop_lead_cycles", 32'(c), 32'd2);
            end
        join
        idle_cycles(2);

        // read-for-ownership hitting a dirty line in core1
        ram_fixed_lat = -1;
        exp_read(0, 32'h200, 1'b1, 1'b1, 32'h11, 32'h22);
        fork
            drive_read(0, 32'h200, 1'b1);
            drive_snooper_dirty(1, 32'h200, 32'h11, 32'h22);
        join
        idle_cycles(2);

        // core1 flush of four words, no snooping allowed
        for (int w = 0; w < 4; w++) wr_data[w] = 32'hF100 + 32'(w);
        exp_write(1, 32'h300, 4);
        no_snoop_chk = 1;
        drive_write(1, 32'h300, 4);
        no_snoop_chk = 0;
        idle_cycles(2);

        // ERROR on the second read word
        @(negedge CLK);
        check_eq("bus_err_before_error", {31'd0, bus_err}, 32'd0);
        err_addr = 32'h704; err_armed = 1;
        exp_read(0, 32'h700, 1'b0, 1'b0, '0, '0);
        drive_read(0, 32'h700, 1'b0);
        @(negedge CLK);
        check_eq("bus_err_set", {31'd0, bus_err}, 32'd1);

        // randomized single-requester traffic
        for (int t = 0; t < 30; t++) begin
            int          kind, k, n;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            k    = int'($urandom_range(0, 1));
            a    = 32'h1000 + {23'd0, 6'($urandom_range(0, 63)), 3'b000};
            if (kind == 0) begin
                bit ccw;
                ccw = 1'($urandom_range(0, 1));
                exp_read(k, a, ccw, 1'b0, '0, '0);
                drive_read(k, a, ccw);
            end else if (kind == 1) begin
                logic [31:0] d0, d1;
                d0 = $urandom; d1 = $urandom;
                exp_read(k, a, 1'b1, 1'b1, d0, d1);
                fork
                    drive_read(k, a, 1'b1);
                    drive_snooper_dirty(1 - k, a, d0, d1);
                join
            end else begin
                n = int'($urandom_range(1, 4));
                for (int w = 0; w < n; w++) wr_data[w] = $urandom;
                exp_write(k, a, n);
                no_snoop_chk = 1;
                drive_write(k, a, n);
                no_snoop_chk = 0;
            end
            idle_cycles(int'($urandom_range(1, 3)));
        end
        @(negedge CLK);
        check_eq("bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // reset during the second READ word
        ram_fixed_lat = 2;
        begin
            snoop_t s;
            s.core = 1; s.addr = 32'h800; s.inv = 1'b0;
            exp_snoop.push_back(s);
            exp_ram.push_back('{1'b0, 32'h800, ref_rd(32'h800)});
            push_resp(0, 1'b1, ref_rd(32'h800));
        end
        @(posedge CLK); #1;
        dREN[0] = 1'b1; daddr[0] = 32'h800;
        g = 0;
        do begin @(negedge CLK); g++; end while (dwait[0] && g < 100);
        check_eq("abort_first_word", {31'd0, dwait[0]}, 32'd0);
        @(posedge CLK); #1;
        daddr[0] = 32'h804;
        @(posedge CLK); #1;
        RST = 1'b1; dREN[0] = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_eq("post_rst_dwait", 32'(dwait), 32'd3);
        check_eq("post_rst_ccwait", 32'(ccwait), 32'd0);
        check_eq("post_rst_ramREN", {31'd0, ramREN}, 32'd0);
        check_eq("post_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check_eq("post_rst_bus_err", {31'd0, bus_err}, 32'd0);
        ram_fixed_lat = -1;
        exp_read(0, 32'h900, 1'b0, 1'b0, '0, '0);
        exp_read(1, 32'hA00, 1'b0, 1'b0, '0, '0);
        fork
            drive_read(0, 32'h900, 1'b0);
            drive_read(1, 32'hA00, 1'b0);
        join
        idle_cycles(4);

        check_eq("ram_queue_drained", 32'(exp_ram.size()), 32'd0);
        check_eq("resp0_queue_drained", 32'(exp_resp0.size()), 32'd0);
        check_eq("resp1_queue_drained", 32'(exp_resp1.size()), 32'd0);
        check_eq("snoop_queue_drained", 32'(exp_snoop.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
